// File: rtl/any_mux_pkg.sv
// Shared helpers for the round-robin streaming mux: index width and pointer reset value.
package any_mux_pkg;

    // Index width that never collapses to zero bits, even for a single channel.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Pointer starts on the last channel so channel 0 wins the first round-robin search.
    function automatic int ptr_reset(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin picker: rotate requests so ptr+1 sits at position 0, take the lowest, rotate back.
module rr_grant
    import any_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int P = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [P-1:0] ptr,
    output logic [N-1:0] gnt
);

    logic [N-1:0] rot;
    logic [N-1:0] pick;
    logic         found;
    logic [P-1:0] idx;

    always_comb begin
        rot   = '0;
        pick  = '0;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx    = P'((int'(ptr) + 1 + k) % N);
            rot[k] = req[idx];
        end
        for (int k = 0; k < N; k++) begin
            if (rot[k] && !found) begin
                pick[k] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            idx      = P'((int'(ptr) + 1 + k) % N);
            gnt[idx] = pick[k];
        end
    end

endmodule

// File: rtl/any_mux_rr.sv
// N-channel valid/ready stream mux with round-robin or forced selection and a registered output stage.
module any_mux_rr
    import any_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    parameter int P = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic           force_sel,
    input  logic [P-1:0]   sel,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [P-1:0]   out_chan
);

    logic [N-1:0] rr_gnt;
    logic [N-1:0] g;
    logic         stage_free;
    logic         xfer;
    logic [P-1:0] gidx;
    logic [W-1:0] gdata;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic [P-1:0] out_chan_q,  out_chan_d;
    logic [P-1:0] ptr_q,       ptr_d;

    rr_grant #(.N(N), .P(P)) u_grant (
        .req (in_valid),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    // Forced mode ignores the pointer; an out-of-range sel simply grants nobody.
    always_comb begin
        g = '0;
        if (force_sel) begin
            if (int'(sel) < N) g[sel] = in_valid[sel];
        end else begin
            g = rr_gnt;
        end
    end

    assign stage_free = !out_valid_q || out_ready;
    assign in_ready   = stage_free ? g : '0;
    assign xfer       = stage_free && (|g);

    always_comb begin
        gidx  = '0;
        gdata = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                gidx  = P'(i);
                gdata = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gdata;
            out_chan_d  = gidx;
            ptr_d       = gidx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= P'(ptr_reset(N));
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_any_mux_rr.sv
// Directed bench for any_mux_rr: stimulus queues expected beats, a negedge monitor pops and compares them.
module tb_any_mux_rr;

    localparam int N = 4;
    localparam int W = 8;
    localparam int P = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data = '0;
    logic           force_sel = 1'b0;
    logic [P-1:0]   sel = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic [P-1:0]   out_chan;

    typedef struct packed {
        logic [P-1:0] chan;
        logic [W-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cnt    = 0;

    any_mux_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .force_sel (force_sel),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", name, act, $time);
        end
    endtask

    // Channel i carries {cycle tag, i} so stale or misrouted data is visible.
    function automatic logic [W-1:0] dval(input int c, input int ch);
        logic [3:0] tag;
        logic [3:0] chn;
        tag = 4'(c);
        chn = 4'(ch);
        return {tag, chn};
    endfunction

    task automatic step(input logic [N-1:0] v, input logic fs, input logic [P-1:0] s,
                        input logic ordy, input logic [N-1:0] exp_rdy, input bit push);
        beat_t b;
        @(posedge clk);
        #1;
        cnt++;
        in_valid  = v;
        force_sel = fs;
        sel       = s;
        out_ready = ordy;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = dval(cnt, i);
        #1;
        check($sformatf("in_ready[c%0d]", cnt), 32'(in_ready), 32'(exp_rdy));
        if (push && exp_rdy != '0) begin
            b.chan = '0;
            for (int i = 0; i < N; i++) if (exp_rdy[i]) b.chan = P'(i);
            b.data = dval(cnt, int'(b.chan));
            exp_q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat: unexpected beat chan=%0d data=%0h, none queued (t=%0t)",
                         out_chan, out_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("beat_chan", 32'(out_chan), 32'(e.chan));
                check("beat_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data",  32'(out_data),  0);
        check("rst_chan",  32'(out_chan),  0);
        check("rst_ready", 32'(in_ready),  0);
        @(posedge clk);
        #1 rst = 1'b0;

        // All channels valid: strict rotation 0,1,2,3,0,...
        step(4'b1111, 0, 0, 1, 4'b0001, 1);
        step(4'b1111, 0, 0, 1, 4'b0010, 1);
        step(4'b1111, 0, 0, 1, 4'b0100, 1);
        step(4'b1111, 0, 0, 1, 4'b1000, 1);
        step(4'b1111, 0, 0, 1, 4'b0001, 1);
        step(4'b1111, 0, 0, 1, 4'b0010, 1);
        step(4'b1111, 0, 0, 1, 4'b0100, 1);
        step(4'b1111, 0, 0, 1, 4'b1000, 1);

        // Consumer stalls: held beat (chan 3 from cycle 8) must not move.
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 0, 0, 0, 4'b0000, 1);
            check("stall_valid", 32'(out_valid), 1);
            check("stall_chan",  32'(out_chan),  3);
            check("stall_data",  32'(out_data),  32'h83);
        end
        step(4'b1111, 0, 0, 1, 4'b0001, 1);

        // Only channels 1 and 3 requesting.
        step(4'b1010, 0, 0, 1, 4'b0010, 1);
        step(4'b1010, 0, 0, 1, 4'b1000, 1);
        step(4'b1010, 0, 0, 1, 4'b0010, 1);
        step(4'b1010, 0, 0, 1, 4'b1000, 1);

        // Forced to channel 2, then back to round-robin from ptr=2.
        step(4'b1111, 1, 2, 1, 4'b0100, 1);
        step(4'b1111, 1, 2, 1, 4'b0100, 1);
        step(4'b1111, 1, 2, 1, 4'b0100, 1);
        step(4'b1111, 0, 0, 1, 4'b1000, 1);

        // Forced onto an idle channel: no grant, held beat drains, stage empties.
        step(4'b1011, 1, 2, 0, 4'b0000, 1);
        step(4'b1011, 1, 2, 1, 4'b0000, 1);
        step(4'b0000, 0, 0, 1, 4'b0000, 1);
        check("drain_valid", 32'(out_valid), 0);

        // Load a beat on channel 1 and reset it away before it is accepted.
        step(4'b0010, 0, 0, 0, 4'b0010, 0);
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(out_valid), 1);
        check("pre_rst_chan",  32'(out_chan),  1);
        check("pre_rst_data",  32'(out_data),  32'h81);
        #2;
        rst      = 1'b1;
        in_valid = '0;
        #1;
        check("async_valid", 32'(out_valid), 0);
        check("async_data",  32'(out_data),  0);
        check("async_chan",  32'(out_chan),  0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Pointer must be back at N-1, so channel 0 wins first.
        step(4'b1111, 0, 0, 1, 4'b0001, 1);
        step(4'b1111, 0, 0, 1, 4'b0010, 1);
        step(4'b0000, 0, 0, 1, 4'b0000, 1);
        step(4'b0000, 0, 0, 1, 4'b0000, 1);
        check("end_valid", 32'(out_valid), 0);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
